// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator.
// Holds the default 640x480@60 timing constants, helpers that derive the
// total line/frame lengths, the vertical region encoding and the coordinate type.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int SYNC_DELAY_DEF = 2;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    V_ACTIVE  = 2'd0,
    V_FRONT_P = 2'd1,
    V_SYNC_P  = 2'd2,
    V_BACK_P  = 2'd3
  } vregion_t;

  function automatic int h_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

  function automatic int v_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift pipeline for a small bundle of sync/blank bits.
// Ports:
//   clk   - pipeline clock
//   rst_n - asynchronous active-low reset, loads RST_VAL into every stage
//   din   - bundle entering the pipeline
//   dout  - bundle delayed by N cycles (combinational passthrough when N == 0)
module vga_sync_delay #(
  parameter int           N       = 2,
  parameter int           W       = 3,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (N == 0) begin : g_pass
      logic unused_s;
      assign unused_s = clk ^ rst_n;
      assign dout     = din;
    end else begin : g_pipe
      logic [W-1:0] stage_q [N];
      logic [W-1:0] stage_d [N];

      // Next value of each stage: stage 0 takes the input, others shift along.
      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < N; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // Stage registers, reset to the idle pattern.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          for (int i = 0; i < N; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Produces the scan position (DrawX, DrawY), the visible flag (blank, 1 = visible),
// active-low hs/vs, copies of hs/vs/blank delayed by SYNC_DELAY cycles, line and
// frame start strobes and an 8-bit wrapping frame counter.
// All primary outputs are registered and computed from the next-state counters so
// they all describe the same pixel in the same cycle.
// Optional build macro VGA_VBLANK_IRQ_EN adds irq_ack (in) and vblank_irq (out),
// a sticky flag raised at the start of vertical blanking.
// Ports:
//   vga_clk     - pixel clock
//   reset_n     - asynchronous active-low reset
//   DrawX/DrawY - current pixel coordinate
//   blank       - 1 while the current pixel is visible
//   hs/vs       - active-low syncs aligned with DrawX/DrawY
//   hs_d/vs_d/blank_d - hs/vs/blank delayed SYNC_DELAY cycles
//   line_start  - high while DrawX == 0
//   frame_start - high while DrawX == 0 and DrawY == 0
//   frame_count - frames started since reset, wraps 255 -> 0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic       vga_clk,
  input  logic       reset_n,
`ifdef VGA_VBLANK_IRQ_EN
  input  logic       irq_ack,
  output logic       vblank_irq,
`endif
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t X_VIS_END    = coord_t'(H_VISIBLE);
  localparam coord_t HS_START     = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END       = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_FP_START   = coord_t'(V_VISIBLE);
  localparam coord_t V_SYNC_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_BACK_START = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  vregion_t   region_q, region_d;
  logic       vis_q, vis_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       line_wrap_s;
  logic [2:0] sync_dly_s;

  // Scan counters: X always advances, Y advances on each line wrap.
  always_comb begin
    line_wrap_s = (x_q == H_LAST);
    if (line_wrap_s) begin
      x_d = 10'd0;
      if (y_q == V_LAST) begin
        y_d = 10'd0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
      y_d = y_q;
    end
  end

  // Vertical region FSM: moves only on a line wrap, keyed on the line being entered.
  always_comb begin
    region_d = region_q;
    if (line_wrap_s) begin
      case (region_q)
        V_ACTIVE: begin
          if (y_d == V_FP_START) region_d = V_FRONT_P;
          else                   region_d = V_ACTIVE;
        end
        V_FRONT_P: begin
          if (y_d == V_SYNC_START) region_d = V_SYNC_P;
          else                     region_d = V_FRONT_P;
        end
        V_SYNC_P: begin
          if (y_d == V_BACK_START) region_d = V_BACK_P;
          else                     region_d = V_SYNC_P;
        end
        V_BACK_P: begin
          if (y_d == 10'd0) region_d = V_ACTIVE;
          else              region_d = V_BACK_P;
        end
        default: region_d = V_BACK_P;
      endcase
    end else begin
      region_d = region_q;
    end
  end

  // Pixel-aligned decodes, taken from next-state so they register with the counters.
  always_comb begin
    vis_d         = (x_d < X_VIS_END) && (region_d == V_ACTIVE);
    hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d       = (region_d != V_SYNC_P);
    line_start_d  = (x_d == 10'd0);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Timing state and registered outputs. Reset parks the scan on the last pixel
  // of the frame so the first edge after release presents (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      region_q      <= V_BACK_P;
      vis_q         <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      region_q      <= region_d;
      vis_q         <= vis_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Bit order {hs, vs, blank}; idle pattern is syncs inactive, not visible.
  vga_sync_delay #(
    .N       (SYNC_DELAY),
    .W       (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   ({hsync_q, vsync_q, vis_q}),
    .dout  (sync_dly_s)
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = vis_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign hs_d        = sync_dly_s[2];
  assign vs_d        = sync_dly_s[1];
  assign blank_d     = sync_dly_s[0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef VGA_VBLANK_IRQ_EN
  logic irq_q, irq_d;
  logic irq_set_s;

  // Sticky vblank flag. The set window covers both the edge entering pixel
  // (0,V_VISIBLE) and the edge leaving it, so the flag reads 1 on that pixel and
  // an ack presented during that pixel cannot clear it.
  always_comb begin
    irq_set_s = ((x_d == 10'd0) && (y_d == V_FP_START)) ||
                ((x_q == 10'd0) && (y_q == V_FP_START));
    if (irq_set_s) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign vblank_irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen.
// dut_a uses full 640x480 timing with SYNC_DELAY=2 for line-level checks;
// dut_b uses a shrunken raster with SYNC_DELAY=0 so whole frames, vertical
// sync, frame strobes and mid-frame resets fit a short run.
// Expected values come from a pixel-index model: after reset release the k-th
// edge presents pixel p=k-1, so X=p%H_TOTAL, Y=(p/H_TOTAL)%V_TOTAL.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int SH_V = 40, SH_F = 4, SH_S = 8, SH_B = 6;
  localparam int SV_V = 30, SV_F = 3, SV_S = 2, SV_B = 4;
  localparam int S_HT = SH_V + SH_F + SH_S + SH_B;   // 58
  localparam int S_VT = SV_V + SV_F + SV_S + SV_B;   // 39
  localparam int S_FR = S_HT * S_VT;                 // 2262

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_blank, a_hs, a_vs, a_hs_d, a_vs_d, a_blank_d, a_ls, a_fs;
  logic b_blank, b_hs, b_vs, b_hs_d, b_vs_d, b_blank_d, b_ls, b_fs;
  logic [7:0] a_fc, b_fc;
`ifdef VGA_VBLANK_IRQ_EN
  logic irq_ack = 1'b0;
  logic a_irq, b_irq;
`endif

  vga_timing_gen dut_a (
    .vga_clk(clk), .reset_n(reset_n),
`ifdef VGA_VBLANK_IRQ_EN
    .irq_ack(irq_ack), .vblank_irq(a_irq),
`endif
    .DrawX(a_x), .DrawY(a_y), .blank(a_blank), .hs(a_hs), .vs(a_vs),
    .hs_d(a_hs_d), .vs_d(a_vs_d), .blank_d(a_blank_d),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .SYNC_DELAY(0)
  ) dut_b (
    .vga_clk(clk), .reset_n(reset_n),
`ifdef VGA_VBLANK_IRQ_EN
    .irq_ack(irq_ack), .vblank_irq(b_irq),
`endif
    .DrawX(b_x), .DrawY(b_y), .blank(b_blank), .hs(b_hs), .vs(b_vs),
    .hs_d(b_hs_d), .vs_d(b_vs_d), .blank_d(b_blank_d),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  logic [35:0] obs_a, obs_b;
  assign obs_a = {a_x, a_y, a_blank, a_hs, a_vs, a_hs_d, a_vs_d, a_blank_d, a_ls, a_fs, a_fc};
  assign obs_b = {b_x, b_y, b_blank, b_hs, b_vs, b_hs_d, b_vs_d, b_blank_d, b_ls, b_fs, b_fc};

  int vectors = 0;
  int miscompares = 0;
  longint p = -1;   // pixel index presented; -1 while in reset

  // Full output vector expected at pixel index pix for a given timing and delay.
  function automatic logic [35:0] model(input int hv, input int hf, input int hsw, input int hb,
                                        input int vv, input int vf, input int vsw, input int vb,
                                        input int d, input longint pix);
    int ht, vt, x, y, xx, yy;
    logic bl, h, v, bd, hd, vd, ls, fs;
    logic [7:0] fc;
    longint q;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (pix < 0) begin
      x = ht - 1; y = vt - 1; bl = 1'b0; h = 1'b1; v = 1'b1; ls = 1'b0; fs = 1'b0; fc = 8'd0;
    end else begin
      x  = int'(pix % ht);
      y  = int'((pix / ht) % vt);
      bl = (x < hv) && (y < vv);
      h  = !((x >= hv + hf) && (x < hv + hf + hsw));
      v  = !((y >= vv + vf) && (y < vv + vf + vsw));
      ls = (x == 0);
      fs = (x == 0) && (y == 0);
      fc = 8'(((pix / (ht * vt)) + 1) % 256);
    end
    q = pix - d;
    if (q < 0) begin
      hd = 1'b1; vd = 1'b1; bd = 1'b0;
    end else begin
      xx = int'(q % ht);
      yy = int'((q / ht) % vt);
      bd = (xx < hv) && (yy < vv);
      hd = !((xx >= hv + hf) && (xx < hv + hf + hsw));
      vd = !((yy >= vv + vf) && (yy < vv + vf + vsw));
    end
    return {10'(x), 10'(y), bl, h, v, hd, vd, bd, ls, fs, fc};
  endfunction

  function automatic logic [35:0] exp_a(input longint pix);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 2, pix);
  endfunction

  function automatic logic [35:0] exp_b(input longint pix);
    return model(SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 0, pix);
  endfunction

  // Expected vertical region of dut_b, from the line number alone.
  function automatic int exp_region_b(input longint pix);
    int y;
    if (pix < 0) y = S_VT - 1;
    else         y = int'((pix / S_HT) % S_VT);
    if (y < SV_V)                    return 0;
    else if (y < SV_V + SV_F)        return 1;
    else if (y < SV_V + SV_F + SV_S) return 2;
    else                             return 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) p = p + 1;
    #1;
  endtask

  // Advance until dut_b's pixel index reaches the given phase within its frame.
  task automatic run_to_phase(input longint phase);
    for (int i = 0; i < S_FR + 2 && (p % S_FR) != phase; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    p = -1;
    repeat (5) tick();
    vectors++; if (obs_a !== exp_a(p)) begin miscompares++; $display("FAIL reset_a: got %h expected %h", obs_a, exp_a(p)); end
    vectors++; if (obs_b !== exp_b(p)) begin miscompares++; $display("FAIL reset_b: got %h expected %h", obs_b, exp_b(p)); end
    vectors++; if (a_x !== 10'd799 || a_y !== 10'd524) begin miscompares++; $display("FAIL reset_xy: got %0d,%0d expected 799,524", a_x, a_y); end
    vectors++; if ({a_hs, a_vs, a_blank} !== 3'b110) begin miscompares++; $display("FAIL reset_sync: got %b expected 110", {a_hs, a_vs, a_blank}); end
    vectors++; if (int'(dut_b.region_q) !== 3) begin miscompares++; $display("FAIL reset_region: got %0d expected 3", int'(dut_b.region_q)); end
`ifdef VGA_VBLANK_IRQ_EN
    vectors++; if ({a_irq, b_irq} !== 2'b00) begin miscompares++; $display("FAIL reset_irq: got %b expected 00", {a_irq, b_irq}); end
`endif
    #3 reset_n = 1'b1;
    tick();
    vectors++; if (a_x !== 10'd0 || a_y !== 10'd0 || a_blank !== 1'b1 || a_fs !== 1'b1 || a_fc !== 8'd1) begin
      miscompares++; $display("FAIL first_pixel: got x=%0d y=%0d blank=%b fs=%b fc=%0d expected 0 0 1 1 1", a_x, a_y, a_blank, a_fs, a_fc);
    end
    vectors++; if (obs_b !== exp_b(p)) begin miscompares++; $display("FAIL first_pixel_b: got %h expected %h", obs_b, exp_b(p)); end
  endtask

  task automatic test_line();
    int hs_low = 0;
    int hs_first = -1;
    int fall_x = -1;
    logic prev_blank;
    prev_blank = a_blank;
    for (int i = 0; i < 800; i++) begin
      tick();
      vectors++; if (obs_a !== exp_a(p)) begin miscompares++; $display("FAIL line_a p=%0d: got %h expected %h", p, obs_a, exp_a(p)); end
      vectors++; if (obs_b !== exp_b(p)) begin miscompares++; $display("FAIL line_b p=%0d: got %h expected %h", p, obs_b, exp_b(p)); end
      if (!a_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(a_x);
      end
      if (prev_blank && !a_blank && fall_x < 0) fall_x = int'(a_x);
      prev_blank = a_blank;
    end
    vectors++; if (fall_x !== 640) begin miscompares++; $display("FAIL blank_fall: got x=%0d expected 640", fall_x); end
    vectors++; if (hs_low !== 96 || hs_first !== 656) begin miscompares++; $display("FAIL hs_width: got %0d from x=%0d expected 96 from 656", hs_low, hs_first); end
    vectors++; if (a_x !== 10'd0 || a_y !== 10'd1 || a_ls !== 1'b1) begin
      miscompares++; $display("FAIL line_wrap: got x=%0d y=%0d ls=%b expected 0 1 1", a_x, a_y, a_ls);
    end
  endtask

  task automatic test_frame();
    int vs_low = 0;
    int fs_cnt = 0;
    run_to_phase(0);
    vectors++; if (b_x !== 10'd0 || b_y !== 10'd0 || b_fs !== 1'b1) begin miscompares++; $display("FAIL frame_align: got %0d,%0d fs=%b expected 0,0 1", b_x, b_y, b_fs); end
    for (int i = 0; i < 2 * S_FR; i++) begin
      tick();
      vectors++; if (obs_b !== exp_b(p)) begin miscompares++; $display("FAIL frame_b p=%0d: got %h expected %h", p, obs_b, exp_b(p)); end
      vectors++; if (int'(dut_b.region_q) !== exp_region_b(p)) begin
        miscompares++; $display("FAIL region p=%0d: got %0d expected %0d", p, int'(dut_b.region_q), exp_region_b(p));
      end
      if (!b_vs) vs_low++;
      if (b_fs) fs_cnt++;
    end
    vectors++; if (vs_low !== 2 * SV_S * S_HT) begin miscompares++; $display("FAIL vs_width: got %0d expected %0d", vs_low, 2 * SV_S * S_HT); end
    vectors++; if (fs_cnt !== 2) begin miscompares++; $display("FAIL frame_strobes: got %0d expected 2", fs_cnt); end
    vectors++; if (obs_a !== exp_a(p)) begin miscompares++; $display("FAIL frame_a p=%0d: got %h expected %h", p, obs_a, exp_a(p)); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) begin
      int n;
      int hold;
      n = int'($urandom_range(1, 3 * S_FR));
      hold = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        tick();
        vectors++; if (obs_b !== exp_b(p)) begin miscompares++; $display("FAIL run_b p=%0d: got %h expected %h", p, obs_b, exp_b(p)); end
      end
      #3 reset_n = 1'b0;
      p = -1;
      #1;
      vectors++; if (obs_a !== exp_a(p)) begin miscompares++; $display("FAIL async_rst_a: got %h expected %h", obs_a, exp_a(p)); end
      vectors++; if (obs_b !== exp_b(p)) begin miscompares++; $display("FAIL async_rst_b: got %h expected %h", obs_b, exp_b(p)); end
      repeat (hold) tick();
      vectors++; if (obs_b !== exp_b(p)) begin miscompares++; $display("FAIL rst_hold_b: got %h expected %h", obs_b, exp_b(p)); end
      #3 reset_n = 1'b1;
      tick();
      vectors++; if (b_x !== 10'd0 || b_y !== 10'd0 || b_fc !== 8'd1 || a_fc !== 8'd1 || a_x !== 10'd0) begin
        miscompares++; $display("FAIL restart: got b=%0d,%0d fc=%0d a_x=%0d a_fc=%0d expected 0,0 1 0 1", b_x, b_y, b_fc, a_x, a_fc);
      end
    end
  endtask

  task automatic test_irq();
`ifdef VGA_VBLANK_IRQ_EN
    longint tgt;
    tgt = SV_V * S_HT;
    run_to_phase(0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    vectors++; if (b_irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear0: got %b expected 0", b_irq); end
    run_to_phase(tgt - 1);
    vectors++; if (b_irq !== 1'b0) begin miscompares++; $display("FAIL irq_before: got %b expected 0", b_irq); end
    tick();
    vectors++; if (b_x !== 10'd0 || b_y !== 10'(SV_V) || b_irq !== 1'b1) begin
      miscompares++; $display("FAIL irq_rise: got %0d,%0d irq=%b expected 0,%0d 1", b_x, b_y, b_irq, SV_V);
    end
    repeat ($urandom_range(5, 40)) tick();
    vectors++; if (b_irq !== 1'b1) begin miscompares++; $display("FAIL irq_sticky: got %b expected 1", b_irq); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    vectors++; if (b_irq !== 1'b0) begin miscompares++; $display("FAIL irq_ack: got %b expected 0", b_irq); end
    run_to_phase(tgt - 1);
    irq_ack = 1'b1;
    tick();
    vectors++; if (b_irq !== 1'b1) begin miscompares++; $display("FAIL irq_set_ack_a: got %b expected 1", b_irq); end
    tick();
    vectors++; if (b_irq !== 1'b1) begin miscompares++; $display("FAIL irq_set_wins: got %b expected 1", b_irq); end
    tick();
    vectors++; if (b_irq !== 1'b0) begin miscompares++; $display("FAIL irq_late_ack: got %b expected 0", b_irq); end
    irq_ack = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
